axi_req_arbiter: RTL and testbench

AXI_REQ_ARBITER -- requirements
Module: axi_req_arbiter

---
 rtl/axi_req_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_axi_req_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_req_arbiter.sv
// Two-client round-robin arbiter feeding a single AXI-style master port.
// Optional WAIT watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module axi_req_arbiter #(
    parameter int AW     = 8,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [AW-1:0] wdata_a,
    input  logic [AW-1:0] wdata_b,
    input  logic [3:0]    len_a,
    input  logic [3:0]    len_b,
    input  logic [3:0]    id_a,
    input  logic [3:0]    id_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          err_a,
    output logic          err_b,
    output logic [1:0]    gnt,
    output logic          en,
    output logic          en_,
    output logic [AW-1:0] ARADDR,
    output logic [AW-1:0] AWADDR,
    output logic [3:0]    ARLEN,
    output logic [3:0]    ARID,
    output logic [3:0]    AWID,
    output logic [AW-1:0] INDATA,
    output logic          LAST,
    input  logic          BVALID,
    input  logic          BREADY,
    input  logic          RVALID,
    input  logic          RREADY,
    input  logic          RLAST
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic          ptr_r;        // 1 = B is favoured on a tie
    logic          owner_b_r;
    logic          we_r;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] wdata_r;
    logic [3:0]    len_r;
    logic [3:0]    id_r;
    logic [1:0]    gnt_r;
    logic          en_rd_r;
    logic          en_wr_r;
    logic          ack_a_r;
    logic          ack_b_r;
    logic          err_a_r;
    logic          err_b_r;

    logic          grant_s;
    logic          grant_b_s;
    logic          done_s;
    logic          timeout_s;
    logic          err_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [AW-1:0] sel_wdata_s;
    logic [3:0]    sel_len_s;
    logic [3:0]    sel_id_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    logic [CW-1:0] cnt_r;

    // WAIT-cycle watchdog counter, cleared whenever the FSM is outside WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && (cnt_r == CW'(TO_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Grant arbitration, completion decode and next-state selection
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        grant_b_s    = req_b & (~req_a | ptr_r);
        done_s       = we_r ? (BVALID & BREADY) : (RVALID & RREADY & RLAST);
        err_s        = timeout_s & ~done_s;
        sel_we_s     = grant_b_s ? we_b    : we_a;
        sel_addr_s   = grant_b_s ? addr_b  : addr_a;
        sel_wdata_s  = grant_b_s ? wdata_b : wdata_a;
        sel_len_s    = grant_b_s ? len_b   : len_a;
        sel_id_s     = grant_b_s ? id_b    : id_a;
        case (state_r)
            ST_IDLE: begin
                if (req_a | req_b) begin
                    grant_s      = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (done_s | timeout_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, holding registers and registered bus/client outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 1'b0;
            owner_b_r <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            len_r     <= 4'd0;
            id_r      <= 4'd0;
            gnt_r     <= 2'b00;
            en_rd_r   <= 1'b0;
            en_wr_r   <= 1'b0;
            ack_a_r   <= 1'b0;
            ack_b_r   <= 1'b0;
            err_a_r   <= 1'b0;
            err_b_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        owner_b_r <= grant_b_s;
                        gnt_r     <= grant_b_s ? 2'b10 : 2'b01;
                        we_r      <= sel_we_s;
                        addr_r    <= sel_addr_s;
                        wdata_r   <= sel_wdata_s;
                        len_r     <= sel_len_s;
                        id_r      <= sel_id_s;
                        en_rd_r   <= ~sel_we_s;
                        en_wr_r   <= sel_we_s;
                    end
                end
                ST_ISSUE: begin
                    en_rd_r <= 1'b0;
                    en_wr_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (state_next_s == ST_DONE) begin
                        ack_a_r <= ~owner_b_r;
                        ack_b_r <= owner_b_r;
                        err_a_r <= ~owner_b_r & err_s;
                        err_b_r <= owner_b_r & err_s;
                    end
                end
                ST_DONE: begin
                    ack_a_r <= 1'b0;
                    ack_b_r <= 1'b0;
                    err_a_r <= 1'b0;
                    err_b_r <= 1'b0;
                    gnt_r   <= 2'b00;
                    ptr_r   <= ~ptr_r;
                end
                default: begin
                    gnt_r <= 2'b00;
                end
            endcase
        end
    end

    assign ack_a  = ack_a_r;
    assign ack_b  = ack_b_r;
    assign err_a  = err_a_r;
    assign err_b  = err_b_r;
    assign gnt    = gnt_r;
    assign en     = en_rd_r;
    assign en_    = en_wr_r;
    assign ARADDR = addr_r;
    assign AWADDR = addr_r;
    assign ARLEN  = len_r;
    assign ARID   = id_r;
    assign AWID   = id_r;
    assign INDATA = wdata_r;
    assign LAST   = 1'b1;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter; define ARB_TIMEOUT_EN to also cover the watchdog.
module tb_axi_req_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a, req_b, we_a, we_b;
    logic [AW-1:0] addr_a, addr_b, wdata_a, wdata_b;
    logic [3:0]    len_a, len_b, id_a, id_b;
    logic          ack_a, ack_b, err_a, err_b;
    logic [1:0]    gnt;
    logic          en, en_;
    logic [AW-1:0] ARADDR, AWADDR, INDATA;
    logic [3:0]    ARLEN, ARID, AWID;
    logic          LAST;
    logic          BVALID, BREADY, RVALID, RREADY, RLAST;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_req_arbiter #(.AW(AW), .TO_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .len_a(len_a), .len_b(len_b), .id_a(id_a), .id_b(id_b),
        .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
        .gnt(gnt), .en(en), .en_(en_),
        .ARADDR(ARADDR), .AWADDR(AWADDR), .ARLEN(ARLEN), .ARID(ARID), .AWID(AWID),
        .INDATA(INDATA), .LAST(LAST),
        .BVALID(BVALID), .BREADY(BREADY), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {req_a, req_b, we_a, we_b} = 4'b0000;
        addr_a = 8'd0; addr_b = 8'd0; wdata_a = 8'd0; wdata_b = 8'd0;
        len_a = 4'd0; len_b = 4'd0; id_a = 4'd0; id_b = 4'd0;
        {BVALID, BREADY, RVALID, RREADY, RLAST} = 5'b00000;

        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_en", 32'({en, en_}), 32'd0);
        chk("rst_ack", 32'({ack_a, ack_b, err_a, err_b}), 32'd0);
        chk("rst_last", 32'(LAST), 32'd1);
        chk("rst_addr", 32'({ARADDR, AWADDR, INDATA}), 32'd0);
        step(); step();
        rst = 1'b1;
        step();

        // A single write; completion held high before grant must be ignored until WAIT
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'd1; wdata_a = 8'd1; id_a = 4'd2;
        BVALID = 1'b1; BREADY = 1'b1;
        step();
        chk("w_gnt", 32'(gnt), 32'd1);
        chk("w_en_", 32'({en, en_}), 32'b01);
        chk("w_awaddr", 32'(AWADDR), 32'd1);
        chk("w_indata", 32'(INDATA), 32'd1);
        chk("w_awid", 32'(AWID), 32'd2);
        BVALID = 1'b0;
        step();
        chk("w_wait_en", 32'({en, en_}), 32'd0);
        step(); step();
        chk("w_wait_noack", 32'({ack_a, ack_b}), 32'd0);
        chk("w_wait_gnt", 32'(gnt), 32'd1);
        BVALID = 1'b1;
        step();
        chk("w_ack", 32'({ack_a, ack_b, err_a}), 32'b100);
        req_a = 1'b0; BVALID = 1'b0; BREADY = 1'b0;
        step();
        chk("w_ack_once", 32'({ack_a, ack_b}), 32'd0);
        chk("w_idle_gnt", 32'(gnt), 32'd0);

        // B read burst; a beat without RLAST must not complete
        req_b = 1'b1; we_b = 1'b0; addr_b = 8'd2; len_b = 4'd3; id_b = 4'd1;
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
        step();
        chk("r_gnt", 32'(gnt), 32'd2);
        chk("r_en", 32'({en, en_}), 32'b10);
        chk("r_ar", 32'({ARADDR, ARLEN, ARID}), 32'h0231);
        RLAST = 1'b0;
        step();
        chk("r_en_once", 32'({en, en_}), 32'd0);
        step();
        chk("r_noack_beat", 32'({ack_a, ack_b}), 32'd0);
        RLAST = 1'b1;
        step();
        chk("r_ack", 32'({ack_a, ack_b, err_b}), 32'b010);
        req_b = 1'b0; {RVALID, RREADY, RLAST} = 3'b000;
        step();
        chk("r_idle", 32'({gnt, ack_b}), 32'd0);

        // Simultaneous requests with pointer back on A: A first, then B
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'd5; wdata_a = 8'd6;
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'd7; wdata_b = 8'd8;
        BVALID = 1'b1; BREADY = 1'b1;
        step();
        chk("rr1_first", 32'({gnt, AWADDR}), {22'd0, 2'b01, 8'd5});
        step();
        step();
        chk("rr1_ack_a", 32'({ack_a, ack_b}), 32'b10);
        req_a = 1'b0;
        step();
        chk("rr1_gap", 32'({gnt, ack_a}), 32'd0);
        step();
        chk("rr1_second", 32'({gnt, AWADDR, INDATA}), {14'd0, 2'b10, 8'd7, 8'd8});
        step(); step();
        chk("rr1_ack_b", 32'({ack_a, ack_b}), 32'b01);
        req_b = 1'b0;
        step();

        // A alone, leaving the pointer on B
        req_a = 1'b1; addr_a = 8'd3;
        step();
        chk("solo_a", 32'(gnt), 32'd1);
        step(); step();
        chk("solo_ack", 32'({ack_a, err_a}), 32'b10);
        req_a = 1'b0;
        step();

        // Repeat the tie: B now goes first
        req_a = 1'b1; req_b = 1'b1;
        step();
        chk("rr2_first", 32'(gnt), 32'd2);
        step(); step();
        chk("rr2_ack_b", 32'({ack_a, ack_b}), 32'b01);
        req_b = 1'b0;
        step(); step();
        chk("rr2_second", 32'(gnt), 32'd1);
        step(); step();
        chk("rr2_ack_a", 32'({ack_a, ack_b}), 32'b10);
        req_a = 1'b0; BVALID = 1'b0; BREADY = 1'b0;
        step();

        // Reset while waiting: outputs clear at once, no ack afterwards
        req_a = 1'b1; addr_a = 8'd4;
        step(); step();
        chk("rw_wait_gnt", 32'(gnt), 32'd1);
        rst = 1'b0;
        #1;
        chk("rw_async", 32'({gnt, en, en_, ack_a, ack_b}), 32'd0);
        chk("rw_last", 32'(LAST), 32'd1);
        req_a = 1'b0;
        step();
        BVALID = 1'b1; BREADY = 1'b1;
        step();
        chk("rw_noack", 32'({ack_a, ack_b}), 32'd0);
        rst = 1'b1; BVALID = 1'b0; BREADY = 1'b0;
        step();
        chk("rw_noack2", 32'({gnt, ack_a, ack_b}), 32'd0);
        req_b = 1'b1; we_b = 1'b0; addr_b = 8'd9;
        step();
        chk("rw_regrant", 32'({gnt, en, ARADDR}), {21'd0, 2'b10, 1'b1, 8'd9});
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
        step(); step();
        chk("rw_ack_b", 32'({ack_b, err_b}), 32'b10);
        req_b = 1'b0; {RVALID, RREADY, RLAST} = 3'b000;
        step();

        // No completion at all
        req_a = 1'b1; we_a = 1'b1;
        step(); step();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_early", 32'({ack_a, err_a}), 32'd0);
        end
        step();
        chk("to_fire", 32'({ack_a, err_a, gnt}), 32'b1101);
        req_a = 1'b0;
        step();
        chk("to_clear", 32'({ack_a, err_a, gnt}), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hang_noack", 32'({ack_a, err_a, err_b}), 32'd0);
        end
        chk("hang_gnt", 32'(gnt), 32'd1);
        rst = 1'b0;
        req_a = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("hang_cleared", 32'({gnt, ack_a}), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
